// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes and
// transmit FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_MARK = 2'b11
    } par_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Character handshake between the host byte source and the UART transmitter.
// A transfer happens on every rising clk edge where s_valid && s_ready; the
// master holds s_data stable while s_valid is high and not yet accepted.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_baud_div.sv
// Bit-period counter: counts 0..div while enabled, pulses tick on the last
// cycle of each period and wraps; held at zero while disabled.
module uart_baud_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] count;

    assign tick = en && (count == div);

    always_ff @(posedge clk) begin
        if (reset || clr || tick || !en) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, DATA_W data bits LSB-first,
// optional parity and one or two stop bits, with the frame config shadowed at accept.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    uart_tx_cfg_if.slave     s,
    output logic             tx_out,
    output logic             busy,
    output logic             baud_tick,
    output tx_state_t        state_dbg
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [DIV_W-1:0]  div_q;
    par_mode_t         par_q;
    logic              two_stop_q;
    logic              stop_second;
    logic              par_bit;
    logic              next_par;
    logic              accept;
    logic              tick;

    assign s.s_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = s.s_valid && s.s_ready;
    assign baud_tick = tick;
    assign state_dbg = state;

    // Parity is taken from the incoming character so it is ready before DATA ends.
    always_comb begin
        next_par = 1'b1;
        case (par_mode_t'(parity_mode))
            PAR_ODD:  next_par = ~^s.s_data;
            PAR_EVEN: next_par = ^s.s_data;
            default:  next_par = 1'b1;
        endcase
    end

    uart_baud_div #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (busy),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_out      <= 1'b1;
            shreg       <= '0;
            bit_idx     <= '0;
            div_q       <= '0;
            par_q       <= PAR_NONE;
            two_stop_q  <= 1'b0;
            stop_second <= 1'b0;
            par_bit     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_out <= 1'b1;
                    if (accept) begin
                        shreg       <= s.s_data;
                        div_q       <= baud_div;
                        par_q       <= par_mode_t'(parity_mode);
                        two_stop_q  <= two_stop;
                        par_bit     <= next_par;
                        stop_second <= 1'b0;
                        bit_idx     <= '0;
                        tx_out      <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: if (tick) begin
                    tx_out  <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: if (tick) begin
                    if (bit_idx == LAST_IDX) begin
                        if (par_q != PAR_NONE) begin
                            tx_out <= par_bit;
                            state  <= ST_PARITY;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= ST_STOP;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                ST_PARITY: if (tick) begin
                    tx_out <= 1'b1;
                    state  <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    // Second stop bit reuses this state for one more period.
                    if (two_stop_q && !stop_second) begin
                        stop_second <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a frame-level model predicts the line per cycle and
// is checked every cycle, plus hand-computed literal frames.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        tx_out, busy, baud_tick;
    tx_state_t   state_dbg;

    uart_tx_cfg_if #(.DATA_W(8)) s_if ();

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .s           (s_if.slave),
        .tx_out      (tx_out),
        .busy        (busy),
        .baud_tick   (baud_tick),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];
    int acc_edge[0:63];
    int acc_n = 0;
    int dut_acc[0:63];
    int dut_acc_n = 0;
    logic rdy_n = 1'b0;
    logic trace_tx[0:4095];
    logic trace_rdy[0:4095];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc + 1, act, exp);
        end
    endtask

    // Each frame is expanded into one {line, tick} entry per clk cycle.
    task automatic model_accept();
        logic bits[$];
        int n;
        int ones;
        n = int'(baud_div) + 1;
        ones = $countones(s_if.s_data);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(s_if.s_data[i]);
        case (parity_mode)
            2'b01: bits.push_back((ones % 2) == 0);
            2'b10: bits.push_back((ones % 2) == 1);
            2'b11: bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (two_stop) bits.push_back(1'b1);
        foreach (bits[k])
            for (int j = 0; j < n; j++) exp_q.push_back({bits[k], (j == n - 1)});
        acc_edge[acc_n % 64] = cyc;
        acc_n++;
    endtask

    always @(posedge clk) begin
        logic was_empty;
        cyc = cyc + 1;
        if (!reset && s_if.s_valid && rdy_n) begin
            dut_acc[dut_acc_n % 64] = cyc;
            dut_acc_n++;
        end
        if (reset) begin
            exp_q.delete();
        end else begin
            was_empty = (exp_q.size() == 0);
            if (!was_empty) void'(exp_q.pop_front());
            if (was_empty && s_if.s_valid) model_accept();
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (cyc >= 1) begin
            e = (exp_q.size() != 0) ? exp_q[0] : 2'b10;
            check("tx_out", {31'd0, tx_out}, {31'd0, e[1]});
            check("baud_tick", {31'd0, baud_tick}, {31'd0, e[0]});
            check("s_ready", {31'd0, s_if.s_ready}, {31'd0, exp_q.size() == 0});
            check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
            if (cyc + 1 < 4096) begin
                trace_tx[cyc + 1]  = tx_out;
                trace_rdy[cyc + 1] = s_if.s_ready;
            end
            rdy_n = s_if.s_ready;
        end
    end

    task automatic wait_acc(input int start, output int a);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (acc_n != start) break;
        end
        if (k == 2000) check("accept_timeout", 32'd0, 32'd1);
        a = acc_edge[(acc_n + 63) % 64];
    endtask

    task automatic send(input logic [7:0] d, output int a);
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        wait_acc(acc_n, a);
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (k == 3000) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle %0d: got timeout want finish", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2;
        int modes[3];
        logic pexp[3];
        logic [9:0]  f8n1;
        logic [9:0]  f3c;
        logic [20:0] fbb;
        modes = '{2, 1, 3};
        pexp  = '{1'b0, 1'b1, 1'b1};
        f8n1 = 10'b1101001010;
        f3c  = 10'b1001111000;
        fbb  = 21'b100001111011010101010;

        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_tx", {31'd0, tx_out}, 32'd1);
        check("rst_ready", {31'd0, s_if.s_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tick", {31'd0, baud_tick}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        // 8N1, 0xA5, four clk per bit
        send(8'hA5, a);
        wait_idle();
        for (int k = 0; k < 10; k++)
            check("8n1_bit", {31'd0, trace_tx[a + 2 + 4 * k]}, {31'd0, f8n1[k]});
        check("8n1_ready40", {31'd0, trace_rdy[a + 40]}, 32'd0);
        check("8n1_ready41", {31'd0, trace_rdy[a + 41]}, 32'd1);

        for (int m = 0; m < 3; m++) begin
            parity_mode = modes[m][1:0];
            send(8'hA5, a);
            wait_idle();
            check("parity_bit", {31'd0, trace_tx[a + 38]}, {31'd0, pexp[m]});
            check("par_ready44", {31'd0, trace_rdy[a + 44]}, 32'd0);
            check("par_ready45", {31'd0, trace_rdy[a + 45]}, 32'd1);
        end

        parity_mode = 2'b00;
        two_stop    = 1'b1;
        send(8'h00, a);
        wait_idle();
        for (int c = 1; c <= 44; c++)
            check("8n2_line", {31'd0, trace_tx[a + c]}, {31'd0, c > 36});
        check("8n2_ready44", {31'd0, trace_rdy[a + 44]}, 32'd0);
        check("8n2_ready45", {31'd0, trace_rdy[a + 45]}, 32'd1);

        // back-to-back with s_valid held, one clk per bit
        two_stop = 1'b0;
        baud_div = 16'd0;
        s_if.s_data  = 8'h55;
        s_if.s_valid = 1'b1;
        wait_acc(acc_n, a1);
        s_if.s_data = 8'h0F;
        wait_acc(acc_n, a2);
        s_if.s_valid = 1'b0;
        wait_idle();
        check("b2b_gap", a2 - a1, 32'd11);
        check("b2b_dut_gap", dut_acc[(dut_acc_n + 63) % 64] - dut_acc[(dut_acc_n + 62) % 64], 32'd11);
        for (int k = 0; k < 21; k++)
            check("b2b_line", {31'd0, trace_tx[a1 + 1 + k]}, {31'd0, fbb[k]});

        // config changes mid-frame only affect the next frame
        baud_div = 16'd3;
        send(8'hC3, a);
        baud_div    = 16'd7;
        parity_mode = 2'b10;
        wait_idle();
        check("iso_ready40", {31'd0, trace_rdy[a + 40]}, 32'd0);
        check("iso_ready41", {31'd0, trace_rdy[a + 41]}, 32'd1);
        send(8'h81, a);
        wait_idle();
        check("iso2_start", {31'd0, trace_tx[a + 8]}, 32'd0);
        check("iso2_bit0", {31'd0, trace_tx[a + 9]}, 32'd1);
        check("iso2_ready88", {31'd0, trace_rdy[a + 88]}, 32'd0);
        check("iso2_ready89", {31'd0, trace_rdy[a + 89]}, 32'd1);

        // reset during data bit 3
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        send(8'hF0, a);
        while (cyc < a + 17) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_tx", {31'd0, tx_out}, 32'd1);
        check("abort_ready", {31'd0, s_if.s_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        send(8'h3C, a);
        wait_idle();
        for (int k = 0; k < 10; k++)
            check("after_rst_bit", {31'd0, trace_tx[a + 2 + 4 * k]}, {31'd0, f3c[k]});

        repeat (3) begin @(posedge clk); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
